// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: shares one slave port between NUM_MASTERS masters,
// holds the grant for a whole cyc, and forces err on accesses the slave never answers.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CW-1:0]          wd_cnt_q, wd_cnt_d;
  logic [LW-1:0]          arb_sel;
  logic                   arb_found;
  logic                   in_grant, gcyc, gstb, resp, timeout_hit;

  // last_q doubles as the granted index while in GRANT
  assign in_grant = (state_q == GRANT);
  assign gcyc     = m_cyc_i[last_q];
  assign gstb     = m_stb_i[last_q];
  assign resp     = s_ack_i | s_err_i | s_rty_i;

  // A slave response in the timeout cycle takes priority over the forced err
  assign timeout_hit = (TIMEOUT != 0) && in_grant && gcyc && gstb && !resp &&
                       (wd_cnt_q == CW'(TIMEOUT));

  assign s_adr_o = m_adr_i[last_q*AW +: AW];
  assign s_dat_o = m_dat_i[last_q*DW +: DW];
  assign s_sel_o = m_sel_i[last_q*SW +: SW];
  assign s_cti_o = m_cti_i[last_q*3 +: 3];
  assign s_bte_o = m_bte_i[last_q*2 +: 2];
  assign s_cyc_o = in_grant && gcyc;
  assign s_stb_o = in_grant && gcyc && gstb && !timeout_hit;
  assign s_we_o  = in_grant && gcyc && m_we_i[last_q];

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = grant_q & {NUM_MASTERS{s_err_i | timeout_hit}};
  assign m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
  assign grant_o = grant_q;

  // First requester after the last winner, with wrap-around
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = last_q;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      if (!arb_found && m_cyc_i[(int'(last_q) + i) % NUM_MASTERS]) begin
        arb_found = 1'b1;
        arb_sel   = LW'((int'(last_q) + i) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    wd_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          last_d  = arb_sel;
          grant_d = NUM_MASTERS'(1) << arb_sel;
        end
      end
      GRANT: begin
        if (!gcyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if ((TIMEOUT != 0) && s_stb_o && !resp) begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      last_q   <= LW'(NUM_MASTERS - 1);
      grant_q  <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule
